// File: rtl/mult_err_pkg.sv
// Shared constants for the approximate-multiplier error monitor: default widths,
// the MNED normaliser and the monitor's state encoding.
package mult_err_pkg;

    localparam int W_DEF         = 8;
    localparam int N_SAMPLES_DEF = 10000;
    localparam int CNT_W_DEF     = 24;
    localparam int SUM_W_DEF     = 40;

    // Largest exact product; software divides MED by this to get MNED.
    localparam int MAX_PROD = (2**W_DEF - 1) * (2**W_DEF - 1);

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/mult_error_monitor_err_dist_stage.sv
// Registered stage 2: signed and absolute error distance between the exact and
// approximate products, plus the mismatch flag, qualified by a valid bit.
module err_dist_stage
    import mult_err_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [2*W-1:0]      exact,
    input  logic [2*W-1:0]      apprx,
    output logic                out_valid,
    output logic signed [2*W:0] ed,
    output logic [2*W-1:0]      abs_ed,
    output logic                mismatch
);

    logic                valid_d, valid_q;
    logic signed [2*W:0] ed_d, ed_q;
    logic [2*W-1:0]      abs_ed_d, abs_ed_q;
    logic                mismatch_d, mismatch_q;

    always_comb begin
        valid_d    = in_valid;
        ed_d       = signed'({1'b0, exact}) - signed'({1'b0, apprx});
        abs_ed_d   = (exact >= apprx) ? (exact - apprx) : (apprx - exact);
        mismatch_d = (exact != apprx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            ed_q       <= '0;
            abs_ed_q   <= '0;
            mismatch_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            ed_q       <= ed_d;
            abs_ed_q   <= abs_ed_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign out_valid = valid_q;
    assign ed        = ed_q;
    assign abs_ed    = abs_ed_q;
    assign mismatch  = mismatch_q;

endmodule

// File: rtl/mult_error_monitor.sv
// Error-metric accumulator for an approximate multiplier: run FSM, input handshake
// (in_valid & in_ready accepts a triple; in_ready is registered and only high in RUN),
// stage-1 exact product, and saturating accumulators fed by err_dist_stage.
module mult_error_monitor
    import mult_err_pkg::*;
#(
    parameter int W         = W_DEF,
    parameter int N_SAMPLES = N_SAMPLES_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int SUM_W     = SUM_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_a,
    input  logic [W-1:0]        in_b,
    input  logic [2*W-1:0]      in_p,
    output logic [CNT_W-1:0]    err_count,
    output logic [CNT_W-1:0]    sample_count,
    output logic [SUM_W-1:0]    sum_ed_abs,
    output logic signed [SUM_W:0] sum_ed,
    output logic [2*W-1:0]      max_ed,
    output logic                busy,
    output logic                done,
    output state_t              dbg_state
);

    // Sums are formed one bit wider than either operand so overflow is visible.
    localparam int AW = ((SUM_W > 2*W) ? SUM_W : 2*W) + 1;
    localparam int SW = ((SUM_W > 2*W) ? SUM_W + 1 : 2*W + 1) + 1;
    localparam logic [AW-1:0]        ABS_LIM = AW'({SUM_W{1'b1}});
    localparam logic signed [SW-1:0] ED_MAX  = SW'({SUM_W{1'b1}});
    localparam logic signed [SW-1:0] ED_MIN  = -ED_MAX - SW'(1);

    state_t             state_d, state_q;
    logic               in_ready_d, in_ready_q;
    logic [CNT_W-1:0]   acc_cnt_d, acc_cnt_q;
    logic               s1_valid_d, s1_valid_q;
    logic [2*W-1:0]     exact_d, exact_q;
    logic [2*W-1:0]     apprx_d, apprx_q;
    logic [CNT_W-1:0]   sample_cnt_d, sample_cnt_q;
    logic [CNT_W-1:0]   err_cnt_d, err_cnt_q;
    logic [SUM_W-1:0]   sum_abs_d, sum_abs_q;
    logic signed [SUM_W:0] sum_ed_d, sum_ed_q;
    logic [2*W-1:0]     max_ed_d, max_ed_q;

    logic                accept;
    logic                clear;
    logic                s2_valid;
    logic signed [2*W:0] s2_ed;
    logic [2*W-1:0]      s2_abs_ed;
    logic                s2_mismatch;
    logic [AW-1:0]       abs_sum_wide;
    logic signed [SW-1:0] ed_sum_wide;

    assign accept = in_valid & in_ready_q;

    always_comb begin
        state_d    = state_q;
        in_ready_d = in_ready_q;
        acc_cnt_d  = acc_cnt_q;
        clear      = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    in_ready_d = 1'b1;
                    acc_cnt_d  = '0;
                    clear      = 1'b1;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    acc_cnt_d = acc_cnt_q + CNT_W'(1);
                    if (acc_cnt_q == CNT_W'(N_SAMPLES - 1)) begin
                        state_d    = ST_DRAIN;
                        in_ready_d = 1'b0;
                    end
                end
            end
            ST_DRAIN: begin
                if (!s1_valid_q && !s2_valid) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s1_valid_d = accept;
        exact_d    = accept ? ((2*W)'(in_a) * (2*W)'(in_b)) : exact_q;
        apprx_d    = accept ? in_p : apprx_q;
    end

    err_dist_stage #(.W(W)) u_err_dist_stage (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid_q),
        .exact     (exact_q),
        .apprx     (apprx_q),
        .out_valid (s2_valid),
        .ed        (s2_ed),
        .abs_ed    (s2_abs_ed),
        .mismatch  (s2_mismatch)
    );

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        sum_abs_d    = sum_abs_q;
        sum_ed_d     = sum_ed_q;
        max_ed_d     = max_ed_q;
        abs_sum_wide = AW'(sum_abs_q) + AW'(s2_abs_ed);
        ed_sum_wide  = SW'(sum_ed_q) + SW'(s2_ed);
        if (clear) begin
            sample_cnt_d = '0;
            err_cnt_d    = '0;
            sum_abs_d    = '0;
            sum_ed_d     = '0;
            max_ed_d     = '0;
        end else if (s2_valid) begin
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
            err_cnt_d    = err_cnt_q + CNT_W'(s2_mismatch);
            sum_abs_d    = (abs_sum_wide > ABS_LIM) ? {SUM_W{1'b1}} : abs_sum_wide[SUM_W-1:0];
            if (ed_sum_wide > ED_MAX) begin
                sum_ed_d = ED_MAX[SUM_W:0];
            end else if (ed_sum_wide < ED_MIN) begin
                sum_ed_d = ED_MIN[SUM_W:0];
            end else begin
                sum_ed_d = ed_sum_wide[SUM_W:0];
            end
            if (s2_abs_ed > max_ed_q) begin
                max_ed_d = s2_abs_ed;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            in_ready_q   <= 1'b0;
            acc_cnt_q    <= '0;
            s1_valid_q   <= 1'b0;
            exact_q      <= '0;
            apprx_q      <= '0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            sum_abs_q    <= '0;
            sum_ed_q     <= '0;
            max_ed_q     <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            acc_cnt_q    <= acc_cnt_d;
            s1_valid_q   <= s1_valid_d;
            exact_q      <= exact_d;
            apprx_q      <= apprx_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            sum_abs_q    <= sum_abs_d;
            sum_ed_q     <= sum_ed_d;
            max_ed_q     <= max_ed_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign err_count    = err_cnt_q;
    assign sample_count = sample_cnt_q;
    assign sum_ed_abs   = sum_abs_q;
    assign sum_ed       = sum_ed_q;
    assign max_ed       = max_ed_q;
    assign busy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done         = (state_q == ST_DONE);
    assign dbg_state    = state_q;

endmodule

// File: doc/mult_error_monitor.md
# mult_error_monitor

Synthesizable error-metric accumulator that sits directly downstream of the 8-bit approximate multiplier (`CSA_Mult_8bits`). It takes each operand pair and the approximate product, recomputes the exact product internally, and accumulates error count, signed and absolute error-distance sums, and maximum error distance over a programmed number of samples. This moves the ER/MED/MNED/max bookkeeping out of simulation-only code into on-chip hardware for FPGA and silicon characterisation.

## Interface
Parameters:
- `W`, 8: operand width. Product width is `2*W`.
- `N_SAMPLES`, 10000: number of accepted samples per measurement run.
- `CNT_W`, 24: width of the sample and error counters. Must satisfy `2**CNT_W > N_SAMPLES`.
- `SUM_W`, 40: width of the absolute error-distance accumulator.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: one-cycle pulse. Clears all accumulators and begins a run.
- `in_valid`, in, 1: the `in_a`/`in_b`/`in_p` triple is valid this cycle.
- `in_ready`, out, 1: high only in RUN while accepted samples < `N_SAMPLES`.
- `in_a`, in, `W`: operand A.
- `in_b`, in, `W`: operand B.
- `in_p`, in, `2*W`: approximate product from the multiplier.
- `err_count`, out, `CNT_W`: number of samples with `exact != in_p`.
- `sample_count`, out, `CNT_W`: number of samples accumulated so far.
- `sum_ed_abs`, out, `SUM_W`: sum of |exact − apprx|. Saturates at all-ones.
- `sum_ed`, out, `SUM_W+1`: signed sum of (exact − apprx), two's complement. Saturates at the signed limits.
- `max_ed`, out, `2*W`: largest |exact − apprx| seen in the run.
- `busy`, out, 1: high in RUN and while the pipeline drains.
- `done`, out, 1: high in DONE state.

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset enters IDLE.
- IDLE: `start` → RUN. On the same edge, clear all accumulators and counters to 0.
- RUN: a sample is accepted on a cycle with `in_valid & in_ready`. The accepted-sample count increments on each acceptance. When the accepted count reaches `N_SAMPLES`, go to DRAIN and drop `in_ready`.
- DRAIN: wait until the pipeline is empty (2 cycles), then go to DONE.
- DONE: outputs hold. `start` → RUN with a fresh clear. `start` is ignored in RUN and DRAIN.
- Pipeline stage 1 registers `exact = in_a*in_b` (unsigned, `2*W` bits) and `apprx = in_p`.
- Pipeline stage 2 computes:
  - `ed = exact − apprx`, signed, `2*W+1` bits.
  - `abs_ed`, `2*W` bits.
  - `mismatch = (exact != apprx)`.
- Accumulate on stage-2 valid:
  - `sample_count += 1`
  - `err_count += mismatch`
  - `sum_ed += ed`
  - `sum_ed_abs += abs_ed`
  - `max_ed = max(max_ed, abs_ed)`
- `sum_ed` accumulates every sample. A zero-error sample contributes 0.
- MED = `sum_ed_abs / N_SAMPLES` and ER = `err_count / N_SAMPLES` are computed by software. The block does no division.
- Zero operands are legal. An exact product of 0 with a nonzero `in_p` counts as an error.

## Timing
- Reset values:
  - state IDLE.
  - `in_ready`, `busy`, `done` all 0.
  - All counters, sums and `max_ed` are 0.
  - Pipeline valids are 0.
- `rst` mid-run aborts immediately. Next cycle is IDLE with everything cleared. Samples in flight are discarded.
- Latency: a sample accepted at edge k is reflected in all outputs after edge k+2.
- `in_ready` is registered. It is 1 the cycle after `start`, and 0 the cycle after the `N_SAMPLES`th acceptance.
- `done` rises 3 cycles after the final acceptance. It stays high until `start` or `rst`.
- `in_valid` while `in_ready` is 0 is ignored; no sample is accepted. Upstream may hold its data.
- `start` and `in_valid` in the same IDLE/DONE cycle: only `start` takes effect. The first sample can be accepted on the next cycle.
- Saturation: once a sum reaches its limit it stays there. Counters never wrap because of the `CNT_W` constraint.
- With the default widths, 10000 samples of worst-case |ed| = 65025 total 650,250,000, so no saturation occurs.

## Structure
- Package `mult_err_pkg` holds:
  - the state enum (IDLE/RUN/DRAIN/DONE);
  - default `W`, `N_SAMPLES`, `CNT_W` and `SUM_W` constants;
  - `MAX_PROD = (2**W−1)**2` (65025 for `W=8`, the MNED normaliser).
- One sub-module, `err_dist_stage`, holds the registered stage-2 logic: exact/apprx in, `ed`/`abs_ed`/`mismatch`/valid out.
- The top level holds:
  - the FSM;
  - the handshake;
  - stage 1;
  - the accumulators.
- The multiplier is not instantiated inside this block. It is connected at the integration level.

## Test plan
- Set `N_SAMPLES=4`. Feed `in_p = in_a*in_b` for (3,5), (255,255), (0,7), (12,12) → `err_count=0`, `sum_ed_abs=0`, `max_ed=0`, `sample_count=4`; `done` is high 3 cycles after the 4th acceptance.
- Feed (255,255) with `in_p=65000`, (10,10) with `in_p=110`, (0,0) with `in_p=1`, (2,3) with `in_p=6` → `err_count=3`, `sum_ed_abs=36`, `sum_ed=+14`, `max_ed=25`.
- Toggle `in_valid` randomly 50%, and hold `in_valid=1` after the last acceptance → exactly `N_SAMPLES` samples counted, and `in_ready=0` after the last one.
- Assert `rst` on the 2nd sample of a run → next cycle is IDLE, all outputs 0, `done=0`. A new `start` then runs a clean measurement.
- Set `SUM_W=8`. Feed 4 samples with `|ed|=100` → `sum_ed_abs` saturates at 255 and stays there; `err_count=4`.
- Pulse `start` in DONE → all accumulators read 0 on the next cycle and `in_ready=1`. A `start` asserted during RUN has no effect.
